// File: rtl/regfile_operand_latch.sv
// 32x32 register file (one write, two read ports) feeding the A/B operand capture registers.
// Operands load one clock after rd_req and are then held stable until the next rd_req or reset.

module mux32to1by32 (
    input  logic [4:0]        sel,
    input  logic [31:0][31:0] in,
    output logic [31:0]       out
);
    assign out = in[sel];
endmodule

module regfile_operand_latch #(
    parameter int ZERO_REG = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    input  logic        rd_req,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data,
    output logic [31:0] a_out,
    output logic [31:0] b_out,
    output logic        ab_valid
);
    localparam logic ST_IDLE     = 1'b0;
    localparam logic ST_CAPTURED = 1'b1;

    localparam logic ZERO_EN = (ZERO_REG != 0);

    logic [31:0][31:0] regs;
    logic [31:0][31:0] mux_in;
    logic [31:0]       raw_a;
    logic [31:0]       raw_b;
    logic [31:0]       next_a;
    logic [31:0]       next_b;
    logic              wr_ok;
    logic              byp_a;
    logic              byp_b;
    logic              state;

    // A write to r0 is dropped when it is hardwired, which also suppresses its bypass.
    assign wr_ok = wr_en && !(ZERO_EN && (wr_addr == 5'd0));
    assign byp_a = wr_ok && (wr_addr == rs_addr);
    assign byp_b = wr_ok && (wr_addr == rt_addr);

    always_comb begin
        mux_in = regs;
        if (ZERO_EN) begin
            mux_in[0] = '0;
        end
    end

    mux32to1by32 u_mux_a (
        .sel (rs_addr),
        .in  (mux_in),
        .out (raw_a)
    );

    mux32to1by32 u_mux_b (
        .sel (rt_addr),
        .in  (mux_in),
        .out (raw_b)
    );

    assign next_a = byp_a ? wr_data : raw_a;
    assign next_b = byp_b ? wr_data : raw_b;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs <= '0;
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            a_out <= '0;
            b_out <= '0;
        end else if (rd_req) begin
            state <= ST_CAPTURED;
            a_out <= next_a;
            b_out <= next_b;
        end else begin
            state <= ST_IDLE;
        end
    end

    assign ab_valid = (state == ST_CAPTURED);
endmodule

// File: doc/regfile_operand_latch.md
Name: regfile_operand_latch

Overview:
- 32-entry register file with one write port and two read ports, plus the A/B operand holding registers for the multicycle CPU.
- Each read path is built from one mux32to1by32 instance, so there are two instances in total; each instance's 32 inputs connect to the 32 storage registers.
- The block captures source operands on request. It holds them stable across the multicycle execute/memory states and accepts write-back from the final state.
- It sits between the decode/control FSM and the ALU operand muxes.

Parameters:
- ZERO_REG, 1, when 1, register 0 reads as zero and ignores writes; when 0, register 0 is ordinary storage.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- rs_addr  input  5  source register address for operand A
- rt_addr  input  5  source register address for operand B
- rd_req  input  1  capture operands at this clock edge
- wr_en  input  1  write-back enable
- wr_addr  input  5  write-back destination
- wr_data  input  32  write-back value
- a_out  output  32  latched operand A
- b_out  output  32  latched operand B
- ab_valid  output  1  one-cycle pulse: a_out/b_out were updated this cycle

Behaviour:
- Reset (asserted, asynchronous):
  - all 32 storage registers = 0
  - a_out = 0, b_out = 0, ab_valid = 0
  - state returns to IDLE immediately
  - a reset that arrives mid-request cancels any pending valid pulse
- Storage write:
  - occurs at the rising edge when wr_en = 1
  - reg[wr_addr] <= wr_data
  - when ZERO_REG = 1 and wr_addr = 0, the write is dropped silently
- Read paths:
  - combinational through the two 32:1 muxes
  - raw_a = reg[rs_addr], raw_b = reg[rt_addr]
  - when ZERO_REG = 1, address 0 yields 0 regardless of storage contents
- Bypass (write-first):
  - applies when rd_req and wr_en are high in the same cycle and wr_addr matches rs_addr and/or rt_addr
  - the matching operand captures wr_data, not the stale storage value
  - no bypass for address 0 when ZERO_REG = 1; that operand captures 0
- State machine, two states: IDLE and CAPTURED.
  - IDLE --rd_req--> CAPTURED: at the edge, a_out/b_out are loaded (with bypass) and ab_valid = 1 for the following cycle.
  - CAPTURED --rd_req--> CAPTURED: reload both operands and pulse ab_valid again.
  - CAPTURED --!rd_req--> IDLE: ab_valid = 0 and a_out/b_out hold their values.
  - In IDLE, a_out/b_out hold the last captured values indefinitely.
- Latency:
  - operands appear 1 clock after the rd_req edge
  - write-back is visible to a raw read 1 clock after the wr_en edge, or the same edge via bypass
- Holding rule: a_out/b_out change only on rd_req edges or reset. A write to the source register after capture does NOT alter a_out/b_out.
- rs_addr = rt_addr is legal: both outputs load the same value.
- Back-to-back rd_req for N cycles gives ab_valid high for N cycles, with fresh operands each cycle.
- No X propagation: every storage element has a defined reset value.

Test Plan:
- Reset, then rd_req with rs = 3, rt = 7 -> a_out = 0, b_out = 0, ab_valid = 1 for exactly one cycle.
- Write 0xDEADBEEF to r5 at cycle 1; rd_req with rs = 5, rt = 5 at cycle 2 -> a_out = b_out = 0xDEADBEEF, ab_valid = 1 at cycle 3.
- Same-cycle wr_en (r9 = 0x12345678) and rd_req (rs = 9, rt = 4, r4 = 0xA) -> a_out = 0x12345678 (bypass), b_out = 0x0000000A.
- ZERO_REG = 1: write 0xFFFFFFFF to r0, then rd_req rs = 0; also same-cycle write r0 with rd_req rs = 0 -> a_out = 0 in both cases. ZERO_REG = 0: same sequence -> a_out = 0xFFFFFFFF.
- Capture r2 = 0x11, then write r2 = 0x22 with no rd_req -> a_out stays 0x11. Next rd_req -> a_out = 0x22.
- Write r6 = 0x55, issue rd_req, and assert reset mid-cycle before the next edge -> a_out = 0, ab_valid = 0, r6 reads 0 afterwards.
